// File: rtl/riscv_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter_if
// Purpose  : IF / MEM requester ports and external bus port of the arbiter.
// Revision : 1.0
// ============================================================================
interface riscv_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction-fetch requester
  logic            IF_req_i;
  logic [AW-1:0]   IF_addr_i;
  logic [DW-1:0]   IF_rdata_o;
  logic            IF_valid_o;
  logic            IF_stall_o;

  // Load/store requester
  logic            MEM_req_i;
  logic            MEM_we_i;
  logic [DW/8-1:0] MEM_be_i;
  logic [AW-1:0]   MEM_addr_i;
  logic [DW-1:0]   MEM_wdata_i;
  logic [DW-1:0]   MEM_rdata_o;
  logic            MEM_valid_o;
  logic            MEM_stall_o;

  // External memory bus
  logic            bus_req_o;
  logic            bus_we_o;
  logic [DW/8-1:0] bus_be_o;
  logic [AW-1:0]   bus_addr_o;
  logic [DW-1:0]   bus_wdata_o;
  logic            bus_ack_i;
  logic [DW-1:0]   bus_rdata_i;
  logic            bus_err_i;

  logic            err_o;
  logic            err_src_o;

  // Arbiter view
  modport master (
    input  IF_req_i, IF_addr_i,
    output IF_rdata_o, IF_valid_o, IF_stall_o,
    input  MEM_req_i, MEM_we_i, MEM_be_i, MEM_addr_i, MEM_wdata_i,
    output MEM_rdata_o, MEM_valid_o, MEM_stall_o,
    output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i, bus_err_i,
    output err_o, err_src_o
  );

  // Requesters and memory view
  modport slave (
    output IF_req_i, IF_addr_i,
    input  IF_rdata_o, IF_valid_o, IF_stall_o,
    output MEM_req_i, MEM_we_i, MEM_be_i, MEM_addr_i, MEM_wdata_i,
    input  MEM_rdata_o, MEM_valid_o, MEM_stall_o,
    input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i, bus_err_i,
    input  err_o, err_src_o
  );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter
// Purpose  : Serializes IF and MEM accesses onto one req/ack memory bus.
// Revision : 1.0
// ============================================================================
module riscv_mem_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MEM_BURST_MAX = 4,
  parameter int TIMEOUT       = 255
) (
  input wire                  clk_i,
  input wire                  rst_i,
  riscv_mem_arbiter_if.master arb
);
  localparam int BW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = (MEM_BURST_MAX < 1) ? 1 : $clog2(MEM_BURST_MAX + 1);

  localparam logic [1:0]    c_S_IDLE     = 2'd0;
  localparam logic [1:0]    c_S_BUSY_IF  = 2'd1;
  localparam logic [1:0]    c_S_BUSY_MEM = 2'd2;
  localparam logic [CW-1:0] c_WAIT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] c_STREAK_MAX = SW'(MEM_BURST_MAX);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [CW-1:0] r_wait;
  logic [SW-1:0] r_streak;

  logic          r_bus_req;
  logic          r_bus_we;
  logic [BW-1:0] r_bus_be;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_mem_rdata;
  logic          r_if_valid;
  logic          r_mem_valid;
  logic          r_err;
  logic          r_err_src;

  logic w_if_elig;
  logic w_mem_elig;
  logic w_grant_if;
  logic w_grant_mem;
  logic w_busy;
  logic w_ack;
  logic w_abort;
  logic w_done;
  logic w_fin_if;
  logic w_fin_mem;
  logic w_fin_err;

  // A requester whose completion pulse is showing is not asking for a new access yet
  assign w_if_elig   = arb.IF_req_i  & ~r_if_valid;
  assign w_mem_elig  = arb.MEM_req_i & ~r_mem_valid;
  assign w_grant_mem = (r_state == c_S_IDLE) & w_mem_elig
                     & ~(w_if_elig & (r_streak == c_STREAK_MAX));
  assign w_grant_if  = (r_state == c_S_IDLE) & w_if_elig & ~w_grant_mem;

  assign w_busy  = (r_state != c_S_IDLE);
  assign w_ack   = w_busy & arb.bus_ack_i;
  assign w_abort = w_busy & ~arb.bus_ack_i & (r_wait == c_WAIT_LAST);
  assign w_done  = w_ack | w_abort;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_grant_mem) begin
          w_next_state = c_S_BUSY_MEM;
        end else if (w_grant_if) begin
          w_next_state = c_S_BUSY_IF;
        end
      end
      c_S_BUSY_IF, c_S_BUSY_MEM: begin
        if (w_done) begin
          w_next_state = c_S_IDLE;
        end
      end
      default: w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_fin_if  = 1'b0;
    w_fin_mem = 1'b0;
    case (r_state)
      c_S_BUSY_IF:  w_fin_if  = w_done;
      c_S_BUSY_MEM: w_fin_mem = w_done;
      default: ;
    endcase
    w_fin_err = w_abort | (w_ack & arb.bus_err_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait   <= '0;
      r_streak <= '0;
    end else begin
      if (w_grant_if | w_grant_mem) begin
        r_wait <= '0;
      end else if (w_busy & ~arb.bus_ack_i) begin
        r_wait <= r_wait + 1'b1;
      end

      // Counts MEM wins while IF is kept waiting; any IF gap or IF win restarts it
      if (~arb.IF_req_i | w_grant_if) begin
        r_streak <= '0;
      end else if (w_grant_mem & (r_streak != c_STREAK_MAX)) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      if (w_grant_mem) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= arb.MEM_we_i;
        r_bus_be    <= arb.MEM_be_i;
        r_bus_addr  <= arb.MEM_addr_i;
        r_bus_wdata <= arb.MEM_wdata_i;
      end else if (w_grant_if) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= 1'b0;
        r_bus_be    <= '1;
        r_bus_addr  <= arb.IF_addr_i;
        r_bus_wdata <= '0;
      end else if (w_done) begin
        r_bus_req   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_src   <= 1'b0;
    end else begin
      r_if_valid  <= w_fin_if;
      r_mem_valid <= w_fin_mem;
      r_err       <= w_fin_err;
      if (w_fin_err) begin
        r_err_src <= (r_state == c_S_BUSY_MEM);
      end
      // An aborted access returns zero rather than whatever is on the bus
      if (w_fin_if) begin
        r_if_rdata <= w_ack ? arb.bus_rdata_i : '0;
      end
      if (w_fin_mem) begin
        r_mem_rdata <= w_ack ? arb.bus_rdata_i : '0;
      end
    end
  end

  assign arb.IF_rdata_o  = r_if_rdata;
  assign arb.IF_valid_o  = r_if_valid;
  assign arb.IF_stall_o  = arb.IF_req_i & ~r_if_valid;
  assign arb.MEM_rdata_o = r_mem_rdata;
  assign arb.MEM_valid_o = r_mem_valid;
  assign arb.MEM_stall_o = arb.MEM_req_i & ~r_mem_valid;
  assign arb.bus_req_o   = r_bus_req;
  assign arb.bus_we_o    = r_bus_we;
  assign arb.bus_be_o    = r_bus_be;
  assign arb.bus_addr_o  = r_bus_addr;
  assign arb.bus_wdata_o = r_bus_wdata;
  assign arb.err_o       = r_err;
  assign arb.err_src_o   = r_err_src;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_arbiter
// Purpose  : Directed and random checks of riscv_mem_arbiter against a model.
// Revision : 1.0
// ============================================================================
module tb_riscv_mem_arbiter;
  localparam int AW            = 32;
  localparam int DW            = 32;
  localparam int BW            = DW / 8;
  localparam int MEM_BURST_MAX = 4;
  localparam int TIMEOUT       = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_mem_arbiter_if #(.AW(AW), .DW(DW)) bif ();

  riscv_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_BURST_MAX(MEM_BURST_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .arb  (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, cycles waited, MEM wins while IF waits
  int            m_owner;
  int            m_wait;
  int            m_streak;
  int            m_grants_if;
  int            m_grants_mem;
  logic          m_bus_req;
  logic          m_bus_we;
  logic [BW-1:0] m_bus_be;
  logic [AW-1:0] m_bus_addr;
  logic [DW-1:0] m_bus_wdata;
  logic          m_if_valid;
  logic          m_mem_valid;
  logic          m_err;
  logic          m_err_src;
  logic [DW-1:0] m_if_rdata;
  logic [DW-1:0] m_mem_rdata;

  int   d_grants_if;
  int   d_grants_mem;
  logic d_prev_req;

  bit auto_req;
  bit auto_bus;
  bit rand_lat;
  bit err_en;
  int fixed_lat;
  int bus_age;
  int bus_lat;

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_streak = 0;
    m_bus_req = 0; m_bus_we = 0; m_bus_be = '0; m_bus_addr = '0; m_bus_wdata = '0;
    m_if_valid = 0; m_mem_valid = 0; m_err = 0; m_err_src = 0;
    m_if_rdata = '0; m_mem_rdata = '0;
    d_prev_req = 0; bus_age = 0;
  endtask

  task automatic idle_inputs();
    bif.IF_req_i = 0; bif.IF_addr_i = '0;
    bif.MEM_req_i = 0; bif.MEM_we_i = 0; bif.MEM_be_i = '0;
    bif.MEM_addr_i = '0; bif.MEM_wdata_i = '0;
    bif.bus_ack_i = 0; bif.bus_rdata_i = '0; bif.bus_err_i = 0;
  endtask

  task automatic model_step();
    bit            if_el, mem_el, ack, fin;
    int            pick;
    logic [DW-1:0] d;
    if_el  = bif.IF_req_i  && !m_if_valid;
    mem_el = bif.MEM_req_i && !m_mem_valid;
    ack    = bif.bus_ack_i;
    m_if_valid = 0; m_mem_valid = 0; m_err = 0;
    if (m_owner == 0) begin
      pick = 0;
      if (if_el && mem_el) pick = (m_streak == MEM_BURST_MAX) ? 1 : 2;
      else if (mem_el)     pick = 2;
      else if (if_el)      pick = 1;
      if (!bif.IF_req_i || pick == 1) m_streak = 0;
      else if (pick == 2 && m_streak < MEM_BURST_MAX) m_streak++;
      if (pick == 1) begin
        m_bus_we = 0; m_bus_be = '1; m_bus_addr = bif.IF_addr_i; m_bus_wdata = '0;
        m_grants_if++;
      end
      if (pick == 2) begin
        m_bus_we = bif.MEM_we_i; m_bus_be = bif.MEM_be_i;
        m_bus_addr = bif.MEM_addr_i; m_bus_wdata = bif.MEM_wdata_i;
        m_grants_mem++;
      end
      if (pick != 0) begin
        m_owner = pick; m_wait = 0; m_bus_req = 1;
      end
    end else begin
      if (!bif.IF_req_i) m_streak = 0;
      fin = ack || (m_wait + 1 == TIMEOUT);
      if (fin) begin
        d = ack ? bif.bus_rdata_i : '0;
        if (m_owner == 1) begin m_if_valid = 1; m_if_rdata = d; end
        else begin m_mem_valid = 1; m_mem_rdata = d; end
        m_err = !ack || bif.bus_err_i;
        if (m_err) m_err_src = (m_owner == 2);
        m_owner = 0; m_bus_req = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic drive_reqs();
    if (!auto_req) return;
    if (bif.IF_req_i) begin
      if (m_if_valid) begin
        if ($urandom_range(0, 1) == 0) bif.IF_req_i = 0;
        else bif.IF_addr_i = $urandom & 32'hFFFF_FFFC;
      end
    end else if ($urandom_range(0, 9) < 4) begin
      bif.IF_req_i = 1; bif.IF_addr_i = $urandom & 32'hFFFF_FFFC;
    end
    if (bif.MEM_req_i) begin
      if (m_mem_valid) begin
        if ($urandom_range(0, 1) == 0) bif.MEM_req_i = 0;
        else begin
          bif.MEM_we_i = 1'($urandom_range(0, 1)); bif.MEM_be_i = 4'($urandom_range(1, 15));
          bif.MEM_addr_i = $urandom; bif.MEM_wdata_i = $urandom;
        end
      end
    end else if ($urandom_range(0, 9) < 4) begin
      bif.MEM_req_i = 1; bif.MEM_we_i = 1'($urandom_range(0, 1));
      bif.MEM_be_i = 4'($urandom_range(1, 15));
      bif.MEM_addr_i = $urandom; bif.MEM_wdata_i = $urandom;
    end
  endtask

  task automatic drive_bus();
    if (!auto_bus) return;
    bif.bus_ack_i = 0; bif.bus_err_i = 0;
    if (m_bus_req) begin
      if (bus_age == 0) bus_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
      if (bus_age == bus_lat) begin
        bif.bus_ack_i = 1; bif.bus_rdata_i = $urandom;
        bif.bus_err_i = err_en && ($urandom_range(0, 7) == 0);
      end
      bus_age++;
    end else begin
      bus_age = 0;
    end
  endtask

  // One clock: stimulus, stall check, model advance, registered-output checks
  task automatic cycle();
    drive_reqs();
    drive_bus();
    #1;
    n_checks++;
    if ({bif.IF_stall_o, bif.MEM_stall_o} !== {bif.IF_req_i & ~m_if_valid, bif.MEM_req_i & ~m_mem_valid}) begin
      n_fail++;
      $display("FAIL stall @%0t: got %b expected %b", $time, {bif.IF_stall_o, bif.MEM_stall_o},
               {bif.IF_req_i & ~m_if_valid, bif.MEM_req_i & ~m_mem_valid});
    end
    model_step();
    @(posedge clk);
    #1;
    n_checks++;
    if ({bif.IF_valid_o, bif.MEM_valid_o, bif.err_o} !== {m_if_valid, m_mem_valid, m_err}) begin
      n_fail++;
      $display("FAIL valid_err @%0t: got %b expected %b", $time,
               {bif.IF_valid_o, bif.MEM_valid_o, bif.err_o}, {m_if_valid, m_mem_valid, m_err});
    end
    if (m_err) begin
      n_checks++;
      if (bif.err_src_o !== m_err_src) begin
        n_fail++;
        $display("FAIL err_src @%0t: got %b expected %b", $time, bif.err_src_o, m_err_src);
      end
    end
    n_checks++;
    if (bif.IF_rdata_o !== m_if_rdata) begin
      n_fail++;
      $display("FAIL if_rdata @%0t: got %h expected %h", $time, bif.IF_rdata_o, m_if_rdata);
    end
    n_checks++;
    if (bif.MEM_rdata_o !== m_mem_rdata) begin
      n_fail++;
      $display("FAIL mem_rdata @%0t: got %h expected %h", $time, bif.MEM_rdata_o, m_mem_rdata);
    end
    n_checks++;
    if (bif.bus_req_o !== m_bus_req) begin
      n_fail++;
      $display("FAIL bus_req @%0t: got %b expected %b", $time, bif.bus_req_o, m_bus_req);
    end
    if (m_bus_req) begin
      n_checks++;
      if ({bif.bus_we_o, bif.bus_be_o, bif.bus_addr_o, bif.bus_wdata_o} !==
          {m_bus_we, m_bus_be, m_bus_addr, m_bus_wdata}) begin
        n_fail++;
        $display("FAIL bus_fields @%0t: got %h expected %h", $time,
                 {bif.bus_we_o, bif.bus_be_o, bif.bus_addr_o, bif.bus_wdata_o},
                 {m_bus_we, m_bus_be, m_bus_addr, m_bus_wdata});
      end
    end
    if (bif.bus_req_o === 1'b1 && !d_prev_req) begin
      if (bif.bus_we_o === 1'b1) d_grants_mem++;
      else d_grants_if++;
    end
    d_prev_req = (bif.bus_req_o === 1'b1);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bif.IF_valid_o, bif.MEM_valid_o, bif.err_o, bif.err_src_o, bif.bus_req_o,
         bif.IF_stall_o, bif.MEM_stall_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0", {bif.IF_valid_o, bif.MEM_valid_o,
               bif.err_o, bif.err_src_o, bif.bus_req_o, bif.IF_stall_o, bif.MEM_stall_o});
    end
    n_checks++;
    if ({bif.IF_rdata_o, bif.MEM_rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 0", {bif.IF_rdata_o, bif.MEM_rdata_o});
    end
    n_checks++;
    if ({bif.bus_we_o, bif.bus_be_o, bif.bus_addr_o, bif.bus_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h expected 0",
               {bif.bus_we_o, bif.bus_be_o, bif.bus_addr_o, bif.bus_wdata_o});
    end
    #3 rst = 0;
    model_reset();
  endtask

  task automatic test_if_single();
    auto_req = 0; auto_bus = 0;
    bif.IF_req_i = 1; bif.IF_addr_i = 32'h100;
    cycle();
    n_checks++;
    if ({bif.bus_req_o, bif.bus_we_o, bif.bus_be_o, bif.bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_fail++;
      $display("FAIL if_single_grant: got %h expected %h",
               {bif.bus_req_o, bif.bus_we_o, bif.bus_be_o, bif.bus_addr_o}, {1'b1, 1'b0, 4'hF, 32'h100});
    end
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'hDEAD_BEEF;
    cycle();
    n_checks++;
    if ({bif.IF_valid_o, bif.bus_req_o, bif.err_o} !== 3'b100 || bif.IF_rdata_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL if_single_done: got %b/%h expected 100/deadbeef",
               {bif.IF_valid_o, bif.bus_req_o, bif.err_o}, bif.IF_rdata_o);
    end
    n_checks++;
    if (bif.IF_stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL if_single_stall: got %b expected 0", bif.IF_stall_o);
    end
    bif.bus_ack_i = 0; bif.IF_req_i = 0;
    cycle();
  endtask

  task automatic test_simultaneous();
    int mem_done, if_grant;
    auto_req = 0; auto_bus = 1; rand_lat = 0; err_en = 0; fixed_lat = 1;
    bif.IF_req_i = 1; bif.IF_addr_i = 32'h300;
    bif.MEM_req_i = 1; bif.MEM_we_i = 1; bif.MEM_be_i = 4'hF;
    bif.MEM_addr_i = 32'h200; bif.MEM_wdata_i = 32'h1234_5678;
    cycle();
    n_checks++;
    if ({bif.bus_we_o, bif.bus_addr_o, bif.bus_wdata_o} !== {1'b1, 32'h200, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL simul_first: got %h expected %h",
               {bif.bus_we_o, bif.bus_addr_o, bif.bus_wdata_o}, {1'b1, 32'h200, 32'h1234_5678});
    end
    mem_done = -1; if_grant = -1;
    for (int k = 0; k < 20 && bif.IF_req_i; k++) begin
      cycle();
      if (bif.MEM_valid_o === 1'b1) begin mem_done = k; bif.MEM_req_i = 0; end
      if (bif.bus_req_o === 1'b1 && bif.bus_addr_o === 32'h300 && if_grant < 0) if_grant = k;
      if (bif.IF_valid_o === 1'b1) bif.IF_req_i = 0;
    end
    n_checks++;
    if (mem_done < 0 || if_grant != mem_done + 1) begin
      n_fail++;
      $display("FAIL simul_order: got if_grant %0d expected %0d", if_grant, mem_done + 1);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_fairness();
    auto_req = 0; auto_bus = 1; rand_lat = 0; err_en = 0; fixed_lat = 0;
    d_grants_if = 0; d_grants_mem = 0; m_grants_if = 0; m_grants_mem = 0;
    bif.IF_req_i = 1; bif.IF_addr_i = 32'h1000;
    bif.MEM_req_i = 1; bif.MEM_we_i = 1; bif.MEM_be_i = 4'h3;
    bif.MEM_addr_i = 32'h2000; bif.MEM_wdata_i = 32'hA5A5_0000;
    repeat (40) cycle();
    n_checks++;
    if (d_grants_if != m_grants_if) begin
      n_fail++;
      $display("FAIL fair_if_grants: got %0d expected %0d", d_grants_if, m_grants_if);
    end
    n_checks++;
    if (d_grants_mem != m_grants_mem) begin
      n_fail++;
      $display("FAIL fair_mem_grants: got %0d expected %0d", d_grants_mem, m_grants_mem);
    end
    bif.IF_req_i = 0; bif.MEM_req_i = 0;
    repeat (3) cycle();
  endtask

  task automatic test_timeout();
    int n;
    auto_req = 0; auto_bus = 0; idle_inputs();
    bif.IF_req_i = 1; bif.IF_addr_i = 32'h400;
    n = 0;
    do begin
      cycle();
      n++;
    end while (bif.IF_valid_o !== 1'b1 && n < TIMEOUT + 40);
    n_checks++;
    if (n != TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d expected %0d", n, TIMEOUT + 1);
    end
    n_checks++;
    if ({bif.err_o, bif.err_src_o, bif.bus_req_o} !== 3'b100 || bif.IF_rdata_o !== '0) begin
      n_fail++;
      $display("FAIL timeout_outputs: got %b/%h expected 100/0",
               {bif.err_o, bif.err_src_o, bif.bus_req_o}, bif.IF_rdata_o);
    end
    bif.IF_req_i = 0;
    cycle();
  endtask

  task automatic test_bus_err();
    auto_req = 0; auto_bus = 0; idle_inputs();
    bif.MEM_req_i = 1; bif.MEM_we_i = 0; bif.MEM_be_i = 4'hF; bif.MEM_addr_i = 32'h500;
    repeat (3) cycle();
    bif.bus_ack_i = 1; bif.bus_err_i = 1; bif.bus_rdata_i = 32'hCAFE_F00D;
    cycle();
    n_checks++;
    if ({bif.MEM_valid_o, bif.err_o, bif.err_src_o} !== 3'b111 || bif.MEM_rdata_o !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL bus_err: got %b/%h expected 111/cafef00d",
               {bif.MEM_valid_o, bif.err_o, bif.err_src_o}, bif.MEM_rdata_o);
    end
    bif.bus_ack_i = 0; bif.bus_err_i = 0; bif.MEM_req_i = 0;
    cycle();
    bif.MEM_req_i = 1; bif.MEM_addr_i = 32'h504;
    cycle();
    repeat (TIMEOUT - 1) cycle();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h1111_1111;
    cycle();
    n_checks++;
    if ({bif.MEM_valid_o, bif.err_o} !== 2'b10 || bif.MEM_rdata_o !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL ack_at_timeout: got %b/%h expected 10/11111111",
               {bif.MEM_valid_o, bif.err_o}, bif.MEM_rdata_o);
    end
    bif.bus_ack_i = 0; bif.MEM_req_i = 0;
    cycle();
  endtask

  task automatic test_reset_mid();
    int seen;
    auto_req = 0; auto_bus = 0; idle_inputs();
    bif.MEM_req_i = 1; bif.MEM_we_i = 1; bif.MEM_be_i = 4'hC;
    bif.MEM_addr_i = 32'h600; bif.MEM_wdata_i = 32'h0BAD_F00D;
    cycle();
    cycle();
    #2;
    rst = 1; bif.MEM_req_i = 0;
    #1;
    n_checks++;
    if ({bif.bus_req_o, bif.bus_we_o, bif.bus_be_o, bif.bus_addr_o, bif.bus_wdata_o,
         bif.MEM_valid_o, bif.IF_valid_o, bif.err_o, bif.MEM_rdata_o, bif.IF_rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h/%h expected 0",
               {bif.bus_req_o, bif.bus_we_o, bif.bus_be_o, bif.bus_addr_o, bif.bus_wdata_o},
               {bif.MEM_valid_o, bif.IF_valid_o, bif.err_o, bif.MEM_rdata_o});
    end
    model_reset();
    @(posedge clk);
    #3 rst = 0;
    auto_bus = 1; rand_lat = 0; err_en = 0; fixed_lat = 0;
    bif.MEM_req_i = 1; bif.MEM_we_i = 0; bif.MEM_be_i = 4'hF; bif.MEM_addr_i = 32'h700;
    seen = 0;
    for (int k = 1; k <= 3 && seen == 0; k++) begin
      cycle();
      if (bif.MEM_valid_o === 1'b1) seen = k;
    end
    n_checks++;
    if (seen != 2) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got valid at %0d expected 2", seen);
    end
    bif.MEM_req_i = 0;
    cycle();
  endtask

  task automatic test_drop_mid();
    int seen;
    auto_req = 0; auto_bus = 1; rand_lat = 0; err_en = 0; fixed_lat = 2;
    bif.IF_req_i = 1; bif.IF_addr_i = 32'h800;
    cycle();
    bif.IF_req_i = 0;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      cycle();
      if (bif.IF_valid_o === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL drop_mid: got no valid pulse expected 1");
    end
    cycle();
  endtask

  task automatic test_random();
    auto_req = 1; auto_bus = 1; rand_lat = 1; err_en = 1;
    repeat (2000) cycle();
    auto_req = 0;
    bif.IF_req_i = 0; bif.MEM_req_i = 0;
    repeat (8) cycle();
  endtask

  initial begin
    auto_req = 0; auto_bus = 0; rand_lat = 0; err_en = 0; fixed_lat = 0;
    m_grants_if = 0; m_grants_mem = 0; d_grants_if = 0; d_grants_mem = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_if_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_bus_err();
    test_reset_mid();
    test_drop_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
